// File: rtl/core_pkg.sv
// Shared core definitions: RV32I opcodes, the scoreboard writer classes,
// and the opcode decode that tells which operands an instruction touches.
package core_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  // Which result latency a destination register has to wait for.
  typedef enum logic [1:0] {
    WCLS_ALU,
    WCLS_LOAD,
    WCLS_MULDIV
  } wcls_e;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wr_rd;
  } dec_t;

  // Source-use and rd-write decode for one opcode.
  function automatic dec_t decode_use(input logic [6:0] opcode);
    dec_t d;
    d = '0;
    case (opcode)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: d.use_rs1 = 1'b1;
      default: ;
    endcase
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: d.wr_rd = 1'b1;
      default: d.wr_rd = 1'b0;
    endcase
    return d;
  endfunction

  // Mul/div takes priority: it is encoded as an OP instruction.
  function automatic wcls_e writer_class(input logic [6:0] opcode, input logic muldiv);
    if (muldiv)                    return WCLS_MULDIV;
    else if (opcode == OPCODE_LOAD) return WCLS_LOAD;
    else                           return WCLS_ALU;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage / writeback view of the hazard scoreboard. The pipeline control
// is the master; the scoreboard is the slave.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic          id_valid_ip;
  logic [6:0]    id_opcode_ip;
  logic          id_muldiv_ip;
  logic [AW-1:0] id_src1_addr_ip;
  logic [AW-1:0] id_src2_addr_ip;
  logic [AW-1:0] id_dest_addr_ip;
  logic          flush_ip;
  logic          wb_valid_ip;
  logic [AW-1:0] wb_dest_addr_ip;
  logic          stall_op;
  logic          issue_op;
  logic          muldiv_busy_op;

  modport master (
    output id_valid_ip, id_opcode_ip, id_muldiv_ip,
    output id_src1_addr_ip, id_src2_addr_ip, id_dest_addr_ip,
    output flush_ip, wb_valid_ip, wb_dest_addr_ip,
    input  stall_op, issue_op, muldiv_busy_op
  );

  modport slave (
    input  id_valid_ip, id_opcode_ip, id_muldiv_ip,
    input  id_src1_addr_ip, id_src2_addr_ip, id_dest_addr_ip,
    input  flush_ip, wb_valid_ip, wb_dest_addr_ip,
    output stall_op, issue_op, muldiv_busy_op
  );
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: the pending bit and result countdown of a single
// architectural register.
module sb_entry (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       clr,
  input  logic [3:0] load_val,
  output logic       pend,
  output logic [3:0] cnt
);

  // Issue claims the register; otherwise writeback releases it and the
  // countdown drains toward zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values; this state is few flops, so it is reset explicitly.
    if (reset) begin
      pend <= 1'b0;
      cnt  <= 4'd0;
    end else if (set) begin
      pend <= 1'b1;
      cnt  <= load_val;
    end else begin
      if (clr)         pend <= 1'b0;
      if (cnt != 4'd0) cnt  <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: detects RAW and mul/div structural hazards for
// the ID-stage instruction and tracks in-flight destination registers.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int FWD_EN     = 1,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int AW    = $clog2(NUM_REGS);
  localparam int DEPTH = 1 << AW;

  dec_t       dec;
  wcls_e      wcls;
  logic [3:0] load_val;
  logic [3:0] busy_cnt;
  logic       pend [DEPTH];
  logic [3:0] cnt  [DEPTH];
  logic       raw_haz;
  logic       struct_haz;
  logic       stall;
  logic       issue;
  logic       issue_wr;

  assign dec  = decode_use(bus.id_opcode_ip);
  assign wcls = writer_class(bus.id_opcode_ip, bus.id_muldiv_ip);

  // With forwarding a producer only blocks until its result reaches the
  // bypass network; without it, until the register file is written (the
  // write-through register file makes the writeback cycle itself safe).
  function automatic logic src_blocked(input logic p, input logic [3:0] c,
                                       input logic wb_hit);
    if (FWD_EN != 0) return p && (c != 4'd0);
    else             return p && !wb_hit;
  endfunction

  // Countdown preload for the destination of the issuing instruction.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the value
    // held, which would otherwise infer a latch.
    load_val = 4'd0;
    case (wcls)
      WCLS_LOAD:   load_val = 4'(LOAD_LAT);
      WCLS_MULDIV: load_val = 4'(MULDIV_LAT - 1);
      default:     load_val = 4'd0;
    endcase
  end

  // Hazard detection and issue decision for the ID instruction.
  always_comb begin
    raw_haz = 1'b0;
    if (dec.use_rs1 && bus.id_src1_addr_ip != '0)
      raw_haz = raw_haz | src_blocked(pend[bus.id_src1_addr_ip], cnt[bus.id_src1_addr_ip],
                  bus.wb_valid_ip && (bus.wb_dest_addr_ip == bus.id_src1_addr_ip));
    if (dec.use_rs2 && bus.id_src2_addr_ip != '0)
      raw_haz = raw_haz | src_blocked(pend[bus.id_src2_addr_ip], cnt[bus.id_src2_addr_ip],
                  bus.wb_valid_ip && (bus.wb_dest_addr_ip == bus.id_src2_addr_ip));
    struct_haz = bus.id_muldiv_ip && (busy_cnt != 4'd0);
    stall      = !reset && bus.id_valid_ip && !bus.flush_ip && (raw_haz || struct_haz);
    issue      = !reset && bus.id_valid_ip && !bus.flush_ip && !stall;
    issue_wr   = issue && dec.wr_rd;
  end

  assign bus.stall_op       = stall;
  assign bus.issue_op       = issue;
  assign bus.muldiv_busy_op = !reset && (busy_cnt != 4'd0);

  // Occupancy of the non-pipelined mul/div unit.
  always_ff @(posedge clk) begin
    if (reset)                           busy_cnt <= 4'd0;
    else if (issue && bus.id_muldiv_ip)  busy_cnt <= 4'(MULDIV_LAT);
    else if (busy_cnt != 4'd0)           busy_cnt <= busy_cnt - 4'd1;
  end

  // x0 and any address beyond NUM_REGS are never pending.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    if (r == 0 || r >= NUM_REGS) begin : g_zero
      assign pend[r] = 1'b0;
      assign cnt[r]  = 4'd0;
    end else begin : g_entry
      sb_entry u_entry (
        .clk      (clk),
        .reset    (reset),
        .set      (issue_wr && (bus.id_dest_addr_ip == AW'(r))),
        .clr      (bus.wb_valid_ip && (bus.wb_dest_addr_ip == AW'(r))),
        .load_val (load_val),
        .pend     (pend[r]),
        .cnt      (cnt[r])
      );
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: instance A forwards (FWD_EN=1), instance B does not.
// Per-cycle vectors are applied from a table; the expected outputs of each
// cycle are queued at drive time and popped when the outputs are sampled.
module tb_hazard_scoreboard;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(32)) bus_a ();
  hazard_scoreboard_if #(.NUM_REGS(32)) bus_b ();

  hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(1), .LOAD_LAT(1), .MULDIV_LAT(4)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(0), .LOAD_LAT(1), .MULDIV_LAT(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    string      name;
    bit         sel_b;
    bit         rst;
    bit         valid;
    logic [6:0] op;
    bit         md;
    int         s1, s2, d;
    bit         fl;
    bit         wbv;
    int         wbd;
    bit         e_stall, e_issue, e_busy;
  } vec_t;

  typedef struct {
    string name;
    logic  stall, issue, busy;
  } exp_t;

  vec_t vecs [$];
  exp_t exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input bit sel_b, input bit rst, input bit valid,
                     input logic [6:0] op, input bit md, input int s1, input int s2,
                     input int d, input bit fl, input bit wbv, input int wbd,
                     input bit es, input bit ei, input bit eb);
    vec_t v;
    v.name = nm; v.sel_b = sel_b; v.rst = rst; v.valid = valid; v.op = op; v.md = md;
    v.s1 = s1; v.s2 = s2; v.d = d; v.fl = fl; v.wbv = wbv; v.wbd = wbd;
    v.e_stall = es; v.e_issue = ei; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input bit valid, input logic [6:0] op, input bit md, input int s1,
                         input int s2, input int d, input bit fl, input bit wbv, input int wbd);
    bus_a.id_valid_ip     = valid;
    bus_a.id_opcode_ip    = op;
    bus_a.id_muldiv_ip    = md;
    bus_a.id_src1_addr_ip = 5'(s1);
    bus_a.id_src2_addr_ip = 5'(s2);
    bus_a.id_dest_addr_ip = 5'(d);
    bus_a.flush_ip        = fl;
    bus_a.wb_valid_ip     = wbv;
    bus_a.wb_dest_addr_ip = 5'(wbd);
  endtask

  task automatic drive_b(input bit valid, input logic [6:0] op, input bit md, input int s1,
                         input int s2, input int d, input bit fl, input bit wbv, input int wbd);
    bus_b.id_valid_ip     = valid;
    bus_b.id_opcode_ip    = op;
    bus_b.id_muldiv_ip    = md;
    bus_b.id_src1_addr_ip = 5'(s1);
    bus_b.id_src2_addr_ip = 5'(s2);
    bus_b.id_dest_addr_ip = 5'(d);
    bus_b.flush_ip        = fl;
    bus_b.wb_valid_ip     = wbv;
    bus_b.wb_dest_addr_ip = 5'(wbd);
  endtask

  // One cycle: drive on the falling edge, sample mid-low-phase.
  task automatic apply_row(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = v.rst;
    if (v.sel_b) begin
      drive_a(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
      drive_b(v.valid, v.op, v.md, v.s1, v.s2, v.d, v.fl, v.wbv, v.wbd);
    end else begin
      drive_b(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
      drive_a(v.valid, v.op, v.md, v.s1, v.s2, v.d, v.fl, v.wbv, v.wbd);
    end
    e.name = v.name; e.stall = v.e_stall; e.issue = v.e_issue; e.busy = v.e_busy;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    if (v.sel_b) begin
      check({got.name, ".stall"}, bus_b.stall_op,       got.stall);
      check({got.name, ".issue"}, bus_b.issue_op,       got.issue);
      check({got.name, ".busy"},  bus_b.muldiv_busy_op, got.busy);
    end else begin
      check({got.name, ".stall"}, bus_a.stall_op,       got.stall);
      check({got.name, ".issue"}, bus_a.issue_op,       got.issue);
      check({got.name, ".busy"},  bus_a.muldiv_busy_op, got.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  stalls;
    bit  done;

    reset = 1'b1;
    drive_a(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);

    //   name          B  rst v  opcode         md s1 s2 d  fl wbv wbd  stall issue busy
    add("rst_a",       0, 1,  1, OPCODE_OP,     0, 1, 2, 3, 0, 0,  0,   0, 0, 0);
    add("rst_b",       1, 1,  1, OPCODE_OP,     0, 1, 2, 3, 0, 0,  0,   0, 0, 0);
    // load-use: exactly one bubble
    add("ld_x5",       0, 0,  1, OPCODE_LOAD,   0, 1, 0, 5, 0, 0,  0,   0, 1, 0);
    add("lu_stall",    0, 0,  1, OPCODE_OP,     0, 5, 7, 6, 0, 0,  0,   1, 0, 0);
    add("lu_issue",    0, 0,  1, OPCODE_OP,     0, 5, 7, 6, 0, 0,  0,   0, 1, 0);
    // ALU back-to-back forwards
    add("addi_x3",     0, 0,  1, OPCODE_OPIMM,  0, 0, 0, 3, 0, 0,  0,   0, 1, 0);
    add("alu_b2b",     0, 0,  1, OPCODE_OP,     0, 3, 3, 4, 0, 0,  0,   0, 1, 0);
    // MUL then dependent: three stalls
    add("mul_x8",      0, 0,  1, OPCODE_OP,     1, 1, 2, 8, 0, 0,  0,   0, 1, 0);
    add("mdep_s1",     0, 0,  1, OPCODE_OPIMM,  0, 8, 0, 9, 0, 0,  0,   1, 0, 1);
    add("mdep_s2",     0, 0,  1, OPCODE_OPIMM,  0, 8, 0, 9, 0, 0,  0,   1, 0, 1);
    add("mdep_s3",     0, 0,  1, OPCODE_OPIMM,  0, 8, 0, 9, 0, 0,  0,   1, 0, 1);
    add("mdep_iss",    0, 0,  1, OPCODE_OPIMM,  0, 8, 0, 9, 0, 0,  0,   0, 1, 1);
    add("md_idle",     0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 0);
    // MUL back-to-back: four structural stalls, busy for four cycles
    add("mul_x10",     0, 0,  1, OPCODE_OP,     1, 0, 0, 10, 0, 0, 0,   0, 1, 0);
    add("mm_s1",       0, 0,  1, OPCODE_OP,     1, 0, 0, 11, 0, 0, 0,   1, 0, 1);
    add("mm_s2",       0, 0,  1, OPCODE_OP,     1, 0, 0, 11, 0, 0, 0,   1, 0, 1);
    add("mm_s3",       0, 0,  1, OPCODE_OP,     1, 0, 0, 11, 0, 0, 0,   1, 0, 1);
    add("mm_s4",       0, 0,  1, OPCODE_OP,     1, 0, 0, 11, 0, 0, 0,   1, 0, 1);
    add("mm_iss",      0, 0,  1, OPCODE_OP,     1, 0, 0, 11, 0, 0, 0,   0, 1, 0);
    add("mm_busy1",    0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 1);
    add("mm_busy2",    0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 1);
    add("mm_busy3",    0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 1);
    add("mm_busy4",    0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 1);
    add("mm_free",     0, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 0,  0,   0, 0, 0);
    // flush squashes the issue and leaves no scoreboard update
    add("ld_flush",    0, 0,  1, OPCODE_LOAD,   0, 0, 0, 12, 1, 0, 0,   0, 0, 0);
    add("after_fl",    0, 0,  1, OPCODE_OP,     0, 12, 0, 13, 0, 0, 0,  0, 1, 0);
    // STORE reads rs2; LUI reads nothing
    add("ld_x14",      0, 0,  1, OPCODE_LOAD,   0, 0, 0, 14, 0, 0, 0,   0, 1, 0);
    add("st_stall",    0, 0,  1, OPCODE_STORE,  0, 0, 14, 0, 0, 0, 0,   1, 0, 0);
    add("st_issue",    0, 0,  1, OPCODE_STORE,  0, 0, 14, 0, 0, 0, 0,   0, 1, 0);
    add("ld_x15",      0, 0,  1, OPCODE_LOAD,   0, 0, 0, 15, 0, 0, 0,   0, 1, 0);
    add("lui_nouse",   0, 0,  1, OPCODE_LUI,    0, 15, 15, 16, 0, 0, 0, 0, 1, 0);
    // flush hides a stall; the bubble it absorbs still counts down
    add("ld_x16",      0, 0,  1, OPCODE_LOAD,   0, 0, 0, 16, 0, 0, 0,   0, 1, 0);
    add("dep_flush",   0, 0,  1, OPCODE_OP,     0, 16, 0, 17, 1, 0, 0,  0, 0, 0);
    add("dep_after",   0, 0,  1, OPCODE_OP,     0, 16, 0, 17, 0, 0, 0,  0, 1, 0);
    // no forwarding: wait for writeback, issue in the writeback cycle
    add("b_addi_x2",   1, 0,  1, OPCODE_OPIMM,  0, 0, 0, 2, 0, 0,  0,   0, 1, 0);
    add("b_sub_s1",    1, 0,  1, OPCODE_OP,     0, 2, 0, 1, 0, 0,  0,   1, 0, 0);
    add("b_sub_s2",    1, 0,  1, OPCODE_OP,     0, 2, 0, 1, 0, 0,  0,   1, 0, 0);
    add("b_sub_wb",    1, 0,  1, OPCODE_OP,     0, 2, 0, 1, 0, 1,  2,   0, 1, 0);
    // x0 is never pending
    add("b_addi_x0",   1, 0,  1, OPCODE_OPIMM,  0, 0, 0, 0, 0, 0,  0,   0, 1, 0);
    add("b_add_x0",    1, 0,  1, OPCODE_OP,     0, 0, 0, 3, 0, 0,  0,   0, 1, 0);
    // writeback of x5 in the issue cycle of LOAD x5: issue wins
    add("b_ld_wb5",    1, 0,  1, OPCODE_LOAD,   0, 0, 0, 5, 0, 1,  5,   0, 1, 0);
    add("b_use5_st",   1, 0,  1, OPCODE_OP,     0, 5, 0, 6, 0, 0,  0,   1, 0, 0);
    add("b_use5_wb",   1, 0,  1, OPCODE_OP,     0, 5, 0, 6, 0, 1,  5,   0, 1, 0);
    add("b_use1_st",   1, 0,  1, OPCODE_OP,     0, 1, 0, 7, 0, 0,  0,   1, 0, 0);
    add("b_use1_wb",   1, 0,  1, OPCODE_OP,     0, 1, 0, 7, 0, 1,  1,   0, 1, 0);
    add("b_wb3_only",  1, 0,  0, OPCODE_OP,     0, 0, 0, 0, 0, 1,  3,   0, 0, 0);
    add("b_use3",      1, 0,  1, OPCODE_OP,     0, 3, 3, 8, 0, 0,  0,   0, 1, 0);
    add("b_jal_x9",    1, 0,  1, OPCODE_JAL,    0, 0, 0, 9, 0, 0,  0,   0, 1, 0);
    add("b_jalr_st",   1, 0,  1, OPCODE_JALR,   0, 9, 0, 0, 0, 0,  0,   1, 0, 0);
    add("b_jalr_wb",   1, 0,  1, OPCODE_JALR,   0, 9, 0, 0, 0, 1,  9,   0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i]);

    // Dependent-on-MUL wait measured with a bounded loop.
    @(negedge clk);
    drive_a(1, OPCODE_OP, 1, 0, 0, 24, 0, 0, 0);
    #2 check("mw_mul_issue", bus_a.issue_op, 1);
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      drive_a(1, OPCODE_OPIMM, 0, 24, 0, 25, 0, 0, 0);
      #2;
      if (bus_a.issue_op)      done = 1;
      else if (bus_a.stall_op) stalls++;
    end
    check("mw_done", 32'(done), 1);
    check("mw_stalls", 32'(stalls), 3);
    @(negedge clk);
    drive_a(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 check("mw_busy_clear", bus_a.muldiv_busy_op, 0);

    // Reset in the middle of a mul/div stall and a no-forward RAW stall.
    @(negedge clk);
    drive_a(1, OPCODE_OP, 1, 0, 0, 20, 0, 0, 0);
    drive_b(1, OPCODE_OPIMM, 0, 0, 0, 22, 0, 0, 0);
    #2;
    check("rm_a_mul", bus_a.issue_op, 1);
    check("rm_b_addi", bus_b.issue_op, 1);
    @(negedge clk);
    drive_a(1, OPCODE_OPIMM, 0, 20, 0, 21, 0, 0, 0);
    drive_b(1, OPCODE_OP, 0, 22, 0, 23, 0, 0, 0);
    #2;
    check("rm_a_stall", bus_a.stall_op, 1);
    check("rm_a_busy", bus_a.muldiv_busy_op, 1);
    check("rm_b_stall", bus_b.stall_op, 1);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rm_rst_a_stall", bus_a.stall_op, 0);
    check("rm_rst_a_issue", bus_a.issue_op, 0);
    check("rm_rst_a_busy", bus_a.muldiv_busy_op, 0);
    check("rm_rst_b_stall", bus_b.stall_op, 0);
    check("rm_rst_b_issue", bus_b.issue_op, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rm_post_a_stall", bus_a.stall_op, 0);
    check("rm_post_a_issue", bus_a.issue_op, 1);
    check("rm_post_a_busy", bus_a.muldiv_busy_op, 0);
    check("rm_post_b_stall", bus_b.stall_op, 0);
    check("rm_post_b_issue", bus_b.issue_op, 1);

    @(negedge clk);
    drive_a(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
